// File: rtl/return_address_stack_if.sv
// Fetch-side bundle for the return address stack.
// The fetch unit is the master; the stack is the slave.
interface return_address_stack_if;
    logic        push;
    logic [31:0] push_addr;
    logic        pop;
    logic [31:0] addr;
    logic        valid;
    logic        branch_fetched;
    logic        branch_retired;
    logic        branch_flush;
    logic        ckpt_full;

    modport master (
        output push, push_addr, pop,
        output branch_fetched, branch_retired, branch_flush,
        input  addr, valid, ckpt_full
    );

    modport slave (
        input  push, push_addr, pop,
        input  branch_fetched, branch_retired, branch_flush,
        output addr, valid, ckpt_full
    );
endinterface

// File: rtl/return_address_stack.sv
// Speculative return address stack with per-branch
// checkpoints of {idx,cnt} restored on a flush.
module return_address_stack #(
    parameter int RAS_DEPTH = 8,
    parameter int MAX_SPEC  = 4
) (
    input logic                   clk,
    input logic                   rst,
    return_address_stack_if.slave bus
);
    localparam int IW = $clog2(RAS_DEPTH);
    localparam int CW = IW + 1;
    localparam int PW = $clog2(MAX_SPEC);
    localparam int OW = PW + 1;

    logic [31:0]   entry_q  [RAS_DEPTH];
    logic [IW-1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [IW-1:0] ck_idx_q [MAX_SPEC];
    logic [CW-1:0] ck_cnt_q [MAX_SPEC];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [OW-1:0] occ_q, occ_d;

    logic [IW-1:0] idx_s;
    logic [CW-1:0] cnt_s;
    logic          we;
    logic [IW-1:0] wptr;
    logic          full, empty, enq, deq;
    logic          ent_we, ck_we;

    assign full  = (occ_q == OW'(MAX_SPEC));
    assign empty = (occ_q == '0);
    assign deq   = bus.branch_retired && !empty;
    assign enq   = bus.branch_fetched && (!full || deq);

    assign bus.addr      = entry_q[idx_q];
    assign bus.valid     = (cnt_q != '0);
    assign bus.ckpt_full = full;

    // Speculative stack update from this cycle's push/pop.
    always_comb begin
        idx_s = idx_q;
        cnt_s = cnt_q;
        we    = 1'b0;
        wptr  = idx_q;
        if (bus.push && bus.pop) begin
            we    = 1'b1;
            cnt_s = (cnt_q == '0) ? CW'(1) : cnt_q;
        end else if (bus.push) begin
            idx_s = idx_q + IW'(1);
            wptr  = idx_q + IW'(1);
            we    = 1'b1;
            if (cnt_q != CW'(RAS_DEPTH))
                cnt_s = cnt_q + CW'(1);
        end else if (bus.pop && cnt_q != '0) begin
            idx_s = idx_q - IW'(1);
            cnt_s = cnt_q - CW'(1);
        end
    end

    // Flush overrides everything; otherwise commit stack and FIFO moves.
    always_comb begin
        ent_we = we && !bus.branch_flush;
        ck_we  = enq && !bus.branch_flush;
        if (bus.branch_flush) begin
            idx_d  = empty ? idx_q : ck_idx_q[head_q];
            cnt_d  = empty ? cnt_q : ck_cnt_q[head_q];
            head_d = '0;
            tail_d = '0;
            occ_d  = '0;
        end else begin
            idx_d  = idx_s;
            cnt_d  = cnt_s;
            head_d = head_q + PW'(deq);
            tail_d = tail_q + PW'(enq);
            occ_d  = occ_q + OW'(enq) - OW'(deq);
        end
    end

    // Pointer and occupancy state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q  <= '0;
            cnt_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    // Entry storage; contents are never reset nor restored.
    always_ff @(posedge clk) begin
        if (ent_we)
            entry_q[wptr] <= bus.push_addr;
    end

    // Checkpoint storage captures post-update {idx,cnt}.
    always_ff @(posedge clk) begin
        if (ck_we) begin
            ck_idx_q[tail_q] <= idx_s;
            ck_cnt_q[tail_q] <= cnt_s;
        end
    end

    // Fetch must stall while the checkpoint FIFO is full.
    assert property (@(posedge clk) disable iff (!rst)
        !(bus.branch_fetched && full &&
          !bus.branch_retired && !bus.branch_flush))
    else $error("ras: branch_fetched while checkpoint FIFO full");
endmodule

// File: tb/tb_return_address_stack.sv
// Directed bench for return_address_stack.
// Inputs change 1ns after a rising edge; outputs are checked mid-cycle.
module tb_return_address_stack;
    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    return_address_stack_if ras_if();

    return_address_stack #(
        .RAS_DEPTH(8),
        .MAX_SPEC (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ras_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic op(input logic        ps,
                      input logic [31:0] pa,
                      input logic        pp,
                      input logic        bf,
                      input logic        br,
                      input logic        fl);
        ras_if.push           = ps;
        ras_if.push_addr      = pa;
        ras_if.pop            = pp;
        ras_if.branch_fetched = bf;
        ras_if.branch_retired = br;
        ras_if.branch_flush   = fl;
        @(posedge clk);
        #1;
        ras_if.push           = 1'b0;
        ras_if.push_addr      = '0;
        ras_if.pop            = 1'b0;
        ras_if.branch_fetched = 1'b0;
        ras_if.branch_retired = 1'b0;
        ras_if.branch_flush   = 1'b0;
        #3;
    endtask

    task automatic push(input logic [31:0] a);
        op(1'b1, a, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop();
        op(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b0;
        ras_if.push           = 1'b0;
        ras_if.push_addr      = '0;
        ras_if.pop            = 1'b0;
        ras_if.branch_fetched = 1'b0;
        ras_if.branch_retired = 1'b0;
        ras_if.branch_flush   = 1'b0;
        #2;
        chk("rst_valid", {31'b0, ras_if.valid}, 32'd0);
        chk("rst_full", {31'b0, ras_if.ckpt_full}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        #3;

        // 1: basic push/pop and underflow
        push(32'h100);
        push(32'h200);
        push(32'h300);
        chk("t1_top", ras_if.addr, 32'h300);
        chk("t1_valid", {31'b0, ras_if.valid}, 32'd1);
        pop();
        chk("t1_pop1", ras_if.addr, 32'h200);
        pop();
        chk("t1_pop2", ras_if.addr, 32'h100);
        pop();
        chk("t1_empty", {31'b0, ras_if.valid}, 32'd0);
        pop();
        chk("t1_under", {31'b0, ras_if.valid}, 32'd0);
        push(32'h500);
        chk("t1_after_under", ras_if.addr, 32'h500);
        pop();
        chk("t1_cnt1", {31'b0, ras_if.valid}, 32'd0);

        // 2: overflow wraps, oldest lost
        for (int i = 0; i < 9; i++)
            push(32'h1000 + 32'(i));
        for (int k = 0; k < 8; k++) begin
            chk("t2_addr", ras_if.addr, 32'h1008 - 32'(k));
            chk("t2_valid", {31'b0, ras_if.valid}, 32'd1);
            pop();
        end
        chk("t2_empty", {31'b0, ras_if.valid}, 32'd0);

        // 3: push and pop together replace top
        push(32'h100);
        push(32'h200);
        op(1'b1, 32'h400, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t3_repl", ras_if.addr, 32'h400);
        pop();
        chk("t3_pop", ras_if.addr, 32'h100);
        pop();
        chk("t3_cnt2", {31'b0, ras_if.valid}, 32'd0);

        // 4: flush restores checkpoint
        push(32'h100);
        op(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        push(32'h200);
        pop();
        pop();
        chk("t4_pre", {31'b0, ras_if.valid}, 32'd0);
        op(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t4_addr", ras_if.addr, 32'h100);
        chk("t4_valid", {31'b0, ras_if.valid}, 32'd1);
        chk("t4_full", {31'b0, ras_if.ckpt_full}, 32'd0);
        pop();
        chk("t4_cnt1", {31'b0, ras_if.valid}, 32'd0);
        op(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t4_empty_flush", {31'b0, ras_if.valid}, 32'd0);

        // 5: checkpoint FIFO full / retire / flush with retire
        op(1'b1, 32'h700, 1'b0, 1'b1, 1'b0, 1'b0);
        op(1'b1, 32'h710, 1'b0, 1'b1, 1'b0, 1'b0);
        op(1'b1, 32'h720, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t5_full3", {31'b0, ras_if.ckpt_full}, 32'd0);
        op(1'b1, 32'h730, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t5_full4", {31'b0, ras_if.ckpt_full}, 32'd1);
        chk("t5_top", ras_if.addr, 32'h730);
        op(1'b1, 32'h740, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("t5_retfetch", {31'b0, ras_if.ckpt_full}, 32'd1);
        op(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t5_retire", {31'b0, ras_if.ckpt_full}, 32'd0);
        chk("t5_top2", ras_if.addr, 32'h740);
        op(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("t5_flush_addr", ras_if.addr, 32'h720);
        chk("t5_flush_full", {31'b0, ras_if.ckpt_full}, 32'd0);
        op(1'b1, 32'h999, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("t5_flush_empty", ras_if.addr, 32'h720);
        pop();
        chk("t5_pop1", ras_if.addr, 32'h710);
        pop();
        chk("t5_pop2", ras_if.addr, 32'h700);
        pop();
        chk("t5_cnt3", {31'b0, ras_if.valid}, 32'd0);

        // 6: asynchronous reset mid-operation
        op(1'b1, 32'hA1, 1'b0, 1'b1, 1'b0, 1'b0);
        push(32'hA2);
        op(1'b1, 32'hA3, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t6_pre", {31'b0, ras_if.valid}, 32'd1);
        rst = 1'b0;
        #1;
        chk("t6_rst_valid", {31'b0, ras_if.valid}, 32'd0);
        chk("t6_rst_full", {31'b0, ras_if.ckpt_full}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        #3;
        push(32'hABC);
        chk("t6_addr", ras_if.addr, 32'hABC);
        chk("t6_valid", {31'b0, ras_if.valid}, 32'd1);
        pop();
        chk("t6_cnt", {31'b0, ras_if.valid}, 32'd0);
        for (int i = 0; i < 3; i++)
            op(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t6_occ3", {31'b0, ras_if.ckpt_full}, 32'd0);
        op(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t6_occ4", {31'b0, ras_if.ckpt_full}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
